// File: rtl/ram_play_seq_pkg.sv
// Shared types and sizing for the frame capture/playback sequencer.
package ram_play_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PLAY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Room for every read in the RAM pipeline plus two words of slack, which
    // lets the read credit loop sustain one word per cycle.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/ram_play_fifo.sv
// Small first-word-fall-through FIFO holding RAM read data ahead of the output port.
// Storage is reset so the head word reads as zero after reset.
module ram_play_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            end
            if (i_pop)
                r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/ram_play_seq.sv
// Captures one frame into a simple-dual-port RAM, then replays it num_play times
// onto a ready/valid stream. Define RAM_PLAY_SEQ_LAST_EN to mark the last word of each pass.
module ram_play_seq
    import ram_play_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 2,
    parameter int PLAY_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [PLAY_WIDTH-1:0] num_play,
    input  logic                  src_vld,
    input  logic [DATA_WIDTH-1:0] src_dat,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    input  logic                  out_rdy,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);
    localparam int DEPTH = fifo_depth(RD_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef RAM_PLAY_SEQ_LAST_EN
    localparam int FW    = DATA_WIDTH + 1;
`else
    localparam int FW    = DATA_WIDTH;
`endif

    state_t                r_state;
    logic [PLAY_WIDTH-1:0] r_num_play;
    logic [PLAY_WIDTH-1:0] r_pass;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic                  r_cap_full;
    logic                  r_rd_done;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drop;
    logic [CW-1:0]         r_inflight;
    logic [RD_LAT-1:0]     r_rd_pipe;

    logic                  w_re;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_src_ok;
    logic                  w_last_word;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_occ;
    logic [FW-1:0]         w_fifo_in;
    logic [FW-1:0]         w_fifo_out;

    // Reads are issued only against free FIFO credit, so returning data never overflows.
    assign w_occ       = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_re        = (r_state == PLAY) && !r_rd_done && (w_occ < (CW+1)'(DEPTH));
    assign w_push      = r_rd_pipe[RD_LAT-1];
    assign w_pop       = !w_empty && out_rdy;
    assign w_src_ok    = (r_state == CAPTURE) && !r_cap_full && src_vld;
    assign w_last_word = w_pop && r_rd_done && (r_inflight == '0) && (w_count == CW'(1));

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state    <= IDLE;
            r_num_play <= '0;
            r_pass     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cap_full <= 1'b0;
            r_rd_done  <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_drop     <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_we <= w_src_ok;
            if (w_src_ok) begin
                r_waddr <= r_wptr;
                r_wdata <= src_dat;
                r_wptr  <= r_wptr + ADDR_WIDTH'(1);
                if (&r_wptr) r_cap_full <= 1'b1;
            end
            if (src_vld && !w_src_ok) r_drop <= 1'b1;

            r_inflight <= r_inflight + CW'(w_re) - CW'(w_push);
            if (w_re) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
                if (&r_rptr) begin
                    r_pass <= r_pass + PLAY_WIDTH'(1);
                    if (r_pass + PLAY_WIDTH'(1) == r_num_play) r_rd_done <= 1'b1;
                end
            end

            case (r_state)
                IDLE: if (start) begin
                    r_num_play <= num_play;
                    r_wptr     <= '0;
                    r_rptr     <= '0;
                    r_pass     <= '0;
                    r_cap_full <= 1'b0;
                    r_rd_done  <= 1'b0;
                    r_drop     <= 1'b0;
                    r_state    <= CAPTURE;
                end
                // Leave only after the all-ones write is actually on the RAM port.
                CAPTURE: if (r_cap_full) r_state <= (r_num_play == '0) ? DONE : PLAY;
                PLAY:    if (w_last_word) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RAM_PLAY_SEQ_LAST_EN
    logic [RD_LAT-1:0] r_last_pipe;
    assign w_fifo_in = {r_last_pipe[RD_LAT-1], ram_rdata};
    assign out_last  = w_fifo_out[DATA_WIDTH];
`else
    assign w_fifo_in = ram_rdata;
    assign out_last  = 1'b0;
`endif

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_rd_pipe <= '0;
`ifdef RAM_PLAY_SEQ_LAST_EN
            r_last_pipe <= '0;
`endif
        end else begin
            r_rd_pipe[0] <= w_re;
            for (int i = 1; i < RD_LAT; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
`ifdef RAM_PLAY_SEQ_LAST_EN
            r_last_pipe[0] <= &r_rptr;
            for (int i = 1; i < RD_LAT; i++) r_last_pipe[i] <= r_last_pipe[i-1];
`endif
        end
    end

    ram_play_fifo #(.DEPTH(DEPTH), .WIDTH(FW), .CW(CW)) u_fifo (
        .clk     (clk),
        .srstn   (srstn),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign ram_we    = r_we;
    assign ram_waddr = r_waddr;
    assign ram_wdata = r_wdata;
    assign ram_re    = w_re;
    assign ram_raddr = r_rptr;
    assign out_vld   = !w_empty;
    assign out_dat   = w_fifo_out[DATA_WIDTH-1:0];
    assign busy      = (r_state == CAPTURE) || (r_state == PLAY);
    assign done      = (r_state == DONE);
    assign drop_err  = r_drop;

endmodule

// File: tb/tb_ram_play_seq.sv
// Bench for ram_play_seq: table of frame scenarios plus reset and protocol sequences.
module tb_ram_play_seq;
    localparam int AW = 4, DW = 16, RL = 2, PW = 8, DEPTH = RL + 2;

    logic          clk = 1'b0, srstn = 1'b0, start = 1'b0, src_vld = 1'b0, out_rdy = 1'b1;
    logic [PW-1:0] num_play = '0;
    logic [DW-1:0] src_dat = '0;
    logic          ram_we, ram_re, out_vld, out_last, busy, done, drop_err;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata, out_dat;

    always #5 clk = ~clk;

    ram_play_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL), .PLAY_WIDTH(PW)) dut (
        .clk(clk), .srstn(srstn), .start(start), .num_play(num_play),
        .src_vld(src_vld), .src_dat(src_dat),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy), .out_last(out_last),
        .busy(busy), .done(done), .drop_err(drop_err)
    );

    // RAM model with a two-cycle read pipeline
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] rd_p1 = '0, rd_p2 = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd_p1 <= mem[ram_raddr];
        rd_p2 <= rd_p1;
    end
    assign ram_rdata = rd_p2;

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    logic [DW-1:0] q_dat[$];
    logic          q_last[$];

    int n_out = 0, n_re = 0, n_we = 0, last_xfer_cyc = 0, tb_out = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (!srstn) begin
            tb_out = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_vld) chk("hold_dat", out_dat, prev_dat);
            if (ram_re) begin
                n_re++;
                chk("read_credit", tb_out < DEPTH, 1);
            end
            if (ram_we) n_we++;
            if (out_vld && out_rdy) begin
                if (q_dat.size() == 0) chk("extra_word", out_dat, 'hFFFF_FFFF);
                else begin
                    chk("out_dat", out_dat, q_dat.pop_front());
`ifdef RAM_PLAY_SEQ_LAST_EN
                    chk("out_last", out_last, q_last.pop_front());
`else
                    chk("out_last", out_last, 0);
`endif
                end
                n_out++;
                last_xfer_cyc = cyc;
            end
            tb_out = tb_out + int'(ram_re) - int'(out_vld && out_rdy);
            prev_stall = out_vld && !out_rdy;
            prev_dat = out_dat;
        end
    end

    int rdy_mode = 0, stall_at = -1;
    initial begin
        int stall_cnt;
        int last_at;
        stall_cnt = 0;
        last_at = -1;
        forever begin
            @(posedge clk); #1;
            if (stall_at >= 0 && stall_at != last_at && n_out >= stall_at) begin
                stall_cnt = 10;
                last_at = stall_at;
            end
            if (stall_cnt > 0) begin
                out_rdy = 1'b0;
                stall_cnt--;
            end else if (rdy_mode == 1) out_rdy = ~out_rdy;
            else out_rdy = 1'b1;
        end
    end

    typedef struct {
        int          np;
        logic [15:0] base;
        int          gap;
        int          rdy;
        bit          inj;
        int          exp_words;
        bit          exp_drop;
    } vec_t;

    task automatic chk_reset_outs();
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_addrs", {ram_waddr, ram_raddr}, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_out_dat", out_dat, 0);
    endtask

    task automatic push_expected(input int np, input logic [15:0] base);
        for (int p = 0; p < np; p++)
            for (int a = 0; a < 16; a++) begin
                q_dat.push_back(DW'(base + 16'(a)));
`ifdef RAM_PLAY_SEQ_LAST_EN
                q_last.push_back(a == 15);
`endif
            end
    endtask

    // Start command then 16 source words spaced gap cycles apart; returns in cycle m.
    task automatic start_and_capture(input int np, input logic [15:0] base, input int gap);
        @(posedge clk); #1;
        start = 1'b1;
        num_play = PW'(np);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("drop_cleared", drop_err, 0);
        for (int a = 0; a < 16; a++) begin
            if (a > 0) repeat (gap - 1) begin @(posedge clk); #1; src_vld = 1'b0; end
            @(posedge clk); #1;
            src_vld = 1'b1;
            src_dat = DW'(base + 16'(a));
        end
        @(posedge clk); #1;
        src_vld = 1'b0;
        @(negedge clk);
        chk("last_we", ram_we, 1);
        chk("last_waddr", ram_waddr, 15);
        chk("last_wdata", ram_wdata, DW'(base + 16'd15));
    endtask

    task automatic run_frame(input vec_t v);
        int out0, re0, we0, first_vld;
        bit ok;
        out0 = n_out; re0 = n_re; we0 = n_we; first_vld = 0; ok = 0;
        rdy_mode = v.rdy;
        if (v.rdy == 1) stall_at = n_out + int'($urandom_range(3, 12));
        push_expected(v.np, v.base);
        start_and_capture(v.np, v.base, v.gap);
        @(negedge clk);
        if (v.np == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
        end else begin
            chk("first_re", ram_re, 1);
            chk("first_raddr", ram_raddr, 0);
            for (int k = 2; k <= 4; k++) begin
                if (k == 2 && v.inj) begin
                    @(posedge clk); #1;
                    src_vld = 1'b1; src_dat = 'hDEAD; start = 1'b1; num_play = 7;
                end
                if (k == 3 && v.inj) begin
                    @(posedge clk); #1;
                    src_vld = 1'b0; start = 1'b0;
                end
                @(negedge clk);
                chk("first_vld_timing", out_vld, k == 4);
            end
            first_vld = cyc;
            for (int i = 0; i < 2000; i++) begin
                if (done) begin ok = 1; break; end
                @(negedge clk);
            end
            chk("done_seen", ok, 1);
            chk("done_after_last", cyc - last_xfer_cyc, 1);
            chk("busy_at_done", busy, 0);
            if (v.rdy == 0) chk("no_bubbles", cyc - first_vld, v.exp_words);
        end
        chk("drop_err", drop_err, v.exp_drop);
        repeat (3) @(negedge clk);
        chk("words_out", n_out - out0, v.exp_words);
        chk("reads_issued", n_re - re0, v.exp_words);
        chk("ram_writes", n_we - we0, 16);
        chk("scoreboard_empty", q_dat.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int out0;
        bit ok;
        tbl[0] = '{1, 16'h0000, 1, 0, 1'b0, 16, 1'b0};  // basic
        tbl[1] = '{3, 16'h0100, 1, 0, 1'b0, 48, 1'b0};  // replay
        tbl[2] = '{2, 16'h0200, 1, 1, 1'b0, 32, 1'b0};  // backpressure
        tbl[3] = '{0, 16'h0300, 1, 0, 1'b0, 0,  1'b0};  // zero replays
        tbl[4] = '{2, 16'h0500, 1, 0, 1'b1, 32, 1'b1};  // src_vld/start during PLAY
        tbl[5] = '{1, 16'h0600, 3, 0, 1'b0, 16, 1'b0};  // sparse input

        repeat (2) @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        srstn = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // Reset in the middle of a three-pass playback
        rdy_mode = 0;
        out0 = n_out;
        ok = 0;
        push_expected(3, 16'h0400);
        start_and_capture(3, 16'h0400, 1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_out - out0 >= 5) begin ok = 1; break; end
        end
        chk("five_outputs_seen", ok, 1);
        @(posedge clk); #1;
        srstn = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        q_dat.delete();
        q_last.delete();
        @(posedge clk); #1;
        srstn = 1'b1;
        v = '{1, 16'h0020, 1, 0, 1'b0, 16, 1'b0};
        run_frame(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
